// File: rtl/dsp_pkg.sv
// Shared DSP definitions: instruction format, opcodes, NOP encoding and
// sequencer state encoding used by dsp_sequencer and dsp_core.
package dsp_pkg;

    localparam int unsigned OPCODE_W    = 6;
    localparam int unsigned DATA_ADDR_W = 10;
    localparam int unsigned INSTR_W     = OPCODE_W + 2 * DATA_ADDR_W;
    localparam int unsigned PROG_ADDR_W = 10;
    localparam int unsigned PIPE_DRAIN  = 4;
    localparam int unsigned OVR_CNT_W   = 16;

    typedef enum logic [OPCODE_W-1:0] {
        OP_NOP   = 6'h00,
        OP_LOAD  = 6'h01,
        OP_MAC   = 6'h02,
        OP_MUL   = 6'h03,
        OP_ADD   = 6'h04,
        OP_STORE = 6'h05,
        OP_CLR   = 6'h06
    } opcode_t;

    typedef struct packed {
        opcode_t                opcode;
        logic [DATA_ADDR_W-1:0] sample_addr;
        logic [DATA_ADDR_W-1:0] param_addr;
    } instr_t;

    localparam instr_t NOP_INSTR = '{opcode: OP_NOP, sample_addr: '0, param_addr: '0};

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_RUN,
        SEQ_DRAIN
    } seq_state_t;

endpackage

// File: rtl/instr_ram.sv
// Two-bank instruction store: simple dual-port, one write and one registered
// read per cycle. The bank select forms the address MSB; contents survive reset.
module instr_ram #(
    parameter int unsigned DATA_WIDTH = 26,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk_i,
    input  logic                  wr_en_i,
    input  logic                  wr_bank_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic                  rd_bank_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    localparam int unsigned DEPTH = 2 ** (ADDR_WIDTH + 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[{wr_bank_i, wr_addr_i}] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[{rd_bank_i, rd_addr_i}];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/dsp_sequencer.sv
// Frame sequencer: on each accepted sample tick, streams prog_len instructions
// from the active RAM bank to the DSP core, then drains the core pipeline.
module dsp_sequencer
    import dsp_pkg::*;
#(
    parameter int unsigned INSTR_WIDTH     = INSTR_W,
    parameter int unsigned PROG_ADDR_WIDTH = PROG_ADDR_W,
    parameter int unsigned PIPE_DEPTH      = PIPE_DRAIN,
    parameter int unsigned OVR_CNT_WIDTH   = OVR_CNT_W
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       sample_tick,
    input  logic [PROG_ADDR_WIDTH:0]   prog_len,
    input  logic                       prog_wr_en,
    input  logic [PROG_ADDR_WIDTH-1:0] prog_wr_addr,
    input  logic [INSTR_WIDTH-1:0]     prog_wr_data,
    input  logic                       swap_req,
    output logic [INSTR_WIDTH-1:0]     instruction,
    output logic                       frame_active,
    output logic                       frame_done,
    output logic                       overrun,
    output logic [OVR_CNT_WIDTH-1:0]   overrun_count,
    output logic                       active_bank
);

    localparam int unsigned DRAIN_W = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
    localparam logic [DRAIN_W-1:0]         DRAIN_LAST = DRAIN_W'(PIPE_DEPTH - 1);
    localparam logic [PROG_ADDR_WIDTH:0]   MAX_LEN    = {1'b1, {PROG_ADDR_WIDTH{1'b0}}};
    localparam logic [PROG_ADDR_WIDTH:0]   LEN_ONE    = (PROG_ADDR_WIDTH + 1)'(1);
    localparam logic [PROG_ADDR_WIDTH-1:0] PC_ONE     = PROG_ADDR_WIDTH'(1);
    localparam logic [DRAIN_W-1:0]         DRAIN_ONE  = DRAIN_W'(1);
    localparam logic [OVR_CNT_WIDTH-1:0]   OVR_ONE    = OVR_CNT_WIDTH'(1);
    localparam logic [INSTR_WIDTH-1:0]     NOP_WORD   = INSTR_WIDTH'(NOP_INSTR);

    seq_state_t                 state_q,   state_d;
    logic [PROG_ADDR_WIDTH-1:0] pc_q,      pc_d;
    logic [PROG_ADDR_WIDTH:0]   len_q,     len_d;
    logic                       last_q,    last_d;
    logic [DRAIN_W-1:0]         drain_q,   drain_d;
    logic                       bank_q,    bank_d;
    logic                       pend_q,    pend_d;
    logic [INSTR_WIDTH-1:0]     instr_q,   instr_d;
    logic                       active_q,  active_d;
    logic                       done_q,    done_d;
    logic                       ovr_q,     ovr_d;
    logic [OVR_CNT_WIDTH-1:0]   ovr_cnt_q, ovr_cnt_d;

    logic                       ram_rd_en;
    logic [INSTR_WIDTH-1:0]     ram_rd_data;
    logic [PROG_ADDR_WIDTH:0]   len_clamped;
    logic                       at_last;

    assign len_clamped = (prog_len > MAX_LEN) ? MAX_LEN : prog_len;
    assign at_last     = ({1'b0, pc_q} == (len_q - LEN_ONE));

    // The RAM is addressed with the next PC so its registered output already holds
    // instruction pc_q; RUN keeps one tail cycle (last_q) to present the final word.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        len_d     = len_q;
        last_d    = last_q;
        drain_d   = drain_q;
        bank_d    = bank_q;
        pend_d    = pend_q | swap_req;
        instr_d   = NOP_WORD;
        done_d    = 1'b0;
        ovr_d     = 1'b0;
        ovr_cnt_d = ovr_cnt_q;
        ram_rd_en = 1'b0;

        case (state_q)
            SEQ_IDLE: begin
                if (sample_tick) begin
                    len_d   = len_clamped;
                    pc_d    = '0;
                    last_d  = 1'b0;
                    drain_d = '0;
                    if (pend_q) begin
                        bank_d = ~bank_q;
                        pend_d = swap_req;
                    end
                    if (len_clamped == '0) begin
                        state_d = SEQ_DRAIN;
                    end else begin
                        state_d   = SEQ_RUN;
                        ram_rd_en = 1'b1;
                    end
                end
            end
            SEQ_RUN: begin
                if (last_q) begin
                    state_d = SEQ_DRAIN;
                end else begin
                    instr_d = ram_rd_data;
                    if (at_last) begin
                        last_d = 1'b1;
                    end else begin
                        pc_d      = pc_q + PC_ONE;
                        ram_rd_en = 1'b1;
                    end
                end
            end
            SEQ_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = SEQ_IDLE;
                    done_d  = 1'b1;
                end else begin
                    drain_d = drain_q + DRAIN_ONE;
                end
            end
            default: begin
                state_d = SEQ_IDLE;
            end
        endcase

        if (sample_tick && (state_q != SEQ_IDLE)) begin
            ovr_d = 1'b1;
            if (ovr_cnt_q != '1) begin
                ovr_cnt_d = ovr_cnt_q + OVR_ONE;
            end
        end

        active_d = (state_d != SEQ_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= SEQ_IDLE;
            pc_q      <= '0;
            len_q     <= '0;
            last_q    <= 1'b0;
            drain_q   <= '0;
            bank_q    <= 1'b0;
            pend_q    <= 1'b0;
            instr_q   <= NOP_WORD;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
            ovr_q     <= 1'b0;
            ovr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            len_q     <= len_d;
            last_q    <= last_d;
            drain_q   <= drain_d;
            bank_q    <= bank_d;
            pend_q    <= pend_d;
            instr_q   <= instr_d;
            active_q  <= active_d;
            done_q    <= done_d;
            ovr_q     <= ovr_d;
            ovr_cnt_q <= ovr_cnt_d;
        end
    end

    instr_ram #(
        .DATA_WIDTH (INSTR_WIDTH),
        .ADDR_WIDTH (PROG_ADDR_WIDTH)
    ) u_instr_ram (
        .clk_i     (clk),
        .wr_en_i   (prog_wr_en),
        .wr_bank_i (~bank_q),
        .wr_addr_i (prog_wr_addr),
        .wr_data_i (prog_wr_data),
        .rd_en_i   (ram_rd_en),
        .rd_bank_i (bank_d),
        .rd_addr_i (pc_d),
        .rd_data_o (ram_rd_data)
    );

    assign instruction   = instr_q;
    assign frame_active  = active_q;
    assign frame_done    = done_q;
    assign overrun       = ovr_q;
    assign overrun_count = ovr_cnt_q;
    assign active_bank   = bank_q;

endmodule

// File: doc/dsp_sequencer.md
DSP_SEQUENCER -- requirements
Module: dsp_sequencer

Interface
REQ-001 Parameter INSTR_WIDTH, 26, instruction word width (6-bit opcode, 10-bit sample address, 10-bit param address).
REQ-002 Parameter PROG_ADDR_WIDTH, 10, instruction-memory address width per bank.
REQ-003 Parameter PIPE_DEPTH, 4, core pipeline drain length in cycles (read, ex1, ex2, writeback).
REQ-004 Parameter OVR_CNT_WIDTH, 16, overrun counter width.
REQ-005 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-006 clk  in  1  core clock; all state updates on its rising edge.
REQ-007 reset_n  in  1  asynchronous active-low reset.
REQ-008 sample_tick  in  1  one-cycle pulse marking the start of an audio frame.
REQ-009 prog_len  in  PROG_ADDR_WIDTH+1  number of instructions per frame; sampled on an accepted tick.
REQ-010 prog_wr_en  in  1  write strobe into the inactive bank.
REQ-011 prog_wr_addr  in  PROG_ADDR_WIDTH  write address.
REQ-012 prog_wr_data  in  INSTR_WIDTH  instruction word to write.
REQ-013 swap_req  in  1  pulse requesting a bank swap at the next accepted tick.
REQ-014 instruction  out  INSTR_WIDTH  registered instruction to the DSP core; all-zero (NOP) when not running.
REQ-015 frame_active  out  1  high while in RUN or DRAIN.
REQ-016 frame_done  out  1  one-cycle pulse when a frame completes.
REQ-017 overrun  out  1  one-cycle pulse when a tick is rejected.
REQ-018 overrun_count  out  OVR_CNT_WIDTH  saturating count of rejected ticks.
REQ-019 active_bank  out  1  bank currently executed.

Function
REQ-020 The FSM SHALL have states IDLE, RUN and DRAIN.
REQ-021 IDLE with sample_tick=1 SHALL latch prog_len, apply any pending swap, and go to RUN; with latched length 0 it SHALL go directly to DRAIN.
REQ-022 For a tick sampled at edge T, the instruction at address k SHALL appear on instruction after edge T+1+k, for k = 0..len-1, one per cycle with no gaps.
REQ-023 After the last instruction, the FSM SHALL spend exactly PIPE_DEPTH cycles in DRAIN, outputting NOP.
REQ-024 frame_done SHALL pulse in the cycle after the last DRAIN cycle, coincident with the return to IDLE.
REQ-025 A tick arriving in RUN or DRAIN SHALL be ignored for execution, SHALL pulse overrun next cycle, and SHALL increment overrun_count, saturating at all-ones.
REQ-026 A tick coincident with the frame_done cycle (state IDLE) SHALL be accepted normally.
REQ-027 swap_req SHALL set a sticky pending flag; an accepted tick with the flag set SHALL toggle active_bank and clear the flag in the same edge.
REQ-028 swap_req coincident with an accepted tick SHALL take effect at the following accepted tick, not the current one.
REQ-029 Writes SHALL always target bank ~active_bank, and SHALL never alter the bank being executed.
REQ-030 The program counter SHALL never exceed len-1.
REQ-031 prog_len values above 2^PROG_ADDR_WIDTH SHALL be clamped to 2^PROG_ADDR_WIDTH.

Reset
REQ-032 While reset_n=0, the block SHALL force state=IDLE, instruction=0, frame_active=0, frame_done=0, overrun=0, overrun_count=0, active_bank=0, swap pending=0, and pc=0; reset takes effect immediately, including mid-frame.
REQ-033 Instruction memory contents SHALL NOT be cleared by reset.

Structure
REQ-034 The shared package dsp_pkg SHALL hold opcode_t, instr_t, the NOP encoding, and the width constants shared with dsp_core.
REQ-035 The two-bank instruction RAM SHALL be a single sub-module, instr_ram: simple dual-port, registered read, one read and one write per cycle.
REQ-036 The FSM, program counter, and overrun logic SHALL live in dsp_sequencer.

Verification
REQ-037 Scenario: len=3, program {A,B,C}, tick at T -> A,B,C after edges T+1..T+3; NOP for 4 cycles; frame_done after edge T+8.
REQ-038 Scenario: len=0, tick -> no non-NOP output; frame_active high for 4 cycles; then one frame_done pulse.
REQ-039 Scenario: tick during RUN with len=10 -> overrun pulse, overrun_count=1, sequence uninterrupted; 65536 extra ticks -> count holds at 0xFFFF.
REQ-040 Scenario: write program P to bank 1 during a frame executing bank 0, then swap_req -> current frame unchanged; next tick executes P and active_bank=1.
REQ-041 Scenario: reset_n low at the 5th instruction of a frame -> instruction=0 and frame_active=0 immediately; after release, a tick restarts from address 0 of bank 0.
REQ-042 Scenario: tick in the same cycle as frame_done -> accepted; no overrun pulse.
